// File: rtl/seg_display_pager.sv
// Time-multiplexed hex display driver: snapshots a wide word on load and pages
// through it NUM_DIGITS nibbles at a time on an active-low 7-segment bank.
module seg_display_pager #(
  parameter  int NUM_DIGITS = 8,
  parameter  int DATA_W     = 128,
  parameter  int SCAN_DIV   = 100000,
  parameter  int PAGE_DIV   = 500000000,
  localparam int NUM_PAGES  = DATA_W / (4 * NUM_DIGITS),
  localparam int PW         = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load,
  input  logic                  auto_en,
  input  logic                  next_page,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [PW-1:0]         page,
  output logic                  page_wrap
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(PAGE_DIV);
  localparam int IW = $clog2(DATA_W);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] PCNT_LAST  = CW'(PAGE_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(NUM_PAGES - 1);

  logic [DATA_W-1:0]     snapshot_q, snapshot_d;
  logic [PW-1:0]         page_q, page_d;
  logic                  page_wrap_q, page_wrap_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [CW-1:0]         page_cnt_q, page_cnt_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  advance;
  logic [IW-1:0]         nib_lo;
  logic [3:0]            nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
    end

    // load wins outright; otherwise a strobe and an auto terminal merge into one step
    snapshot_d  = snapshot_q;
    page_d      = page_q;
    page_cnt_d  = page_cnt_q;
    page_wrap_d = 1'b0;
    advance     = next_page || (auto_en && (page_cnt_q == PCNT_LAST));
    if (load) begin
      snapshot_d = data_in;
      page_d     = '0;
      page_cnt_d = '0;
    end else begin
      if (advance) begin
        page_cnt_d = '0;
      end else if (auto_en) begin
        page_cnt_d = page_cnt_q + 1'b1;
      end
      if (advance) begin
        if (page_q == PAGE_LAST) begin
          page_d      = '0;
          page_wrap_d = 1'b1;
        end else begin
          page_d = page_q + 1'b1;
        end
      end
    end

    // page 0 holds the top nibbles, so it sits at the highest nibble group
    nib_lo = IW'(4 * ((NUM_PAGES - 1 - int'(page_q)) * NUM_DIGITS + int'(digit_q)));
    nibble = 4'(snapshot_q >> nib_lo);

    an_d  = ~(NUM_DIGITS'(1) << digit_q);
    seg_d = hex_to_seg(nibble);
    dp_d  = !(int'(digit_q) == int'(page_q));
    if (blank) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot_q  <= '0;
      page_q      <= '0;
      page_wrap_q <= 1'b0;
      digit_q     <= '0;
      scan_cnt_q  <= '0;
      page_cnt_q  <= '0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= '1;
    end else begin
      snapshot_q  <= snapshot_d;
      page_q      <= page_d;
      page_wrap_q <= page_wrap_d;
      digit_q     <= digit_d;
      scan_cnt_q  <= scan_cnt_d;
      page_cnt_q  <= page_cnt_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign page      = page_q;
  assign page_wrap = page_wrap_q;

endmodule
